// File: rtl/bus_pkg.sv
// bus_pkg: shared state type, default decode windows and
// index-width helpers for the bus interconnect.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    COMPLETE
  } state_t;

  localparam int MAX_PORTS = 8;
  localparam int MAX_IDX_W = $clog2(MAX_PORTS);

  localparam logic [31:0] DEF_MASK = 32'hF000_0000;
  localparam logic [63:0] DEF_SLAVE_BASE =
    {32'h1000_0000, 32'h0000_0000};
  localparam logic [63:0] DEF_SLAVE_MASK =
    {DEF_MASK, DEF_MASK};

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: combinational one-hot grant, round-robin
// from last_grant+1 or fixed lowest-index priority.
module bus_rr_arbiter
  import bus_pkg::*;
#(
  parameter int NM             = 3,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [NM-1:0]        i_request,
  input  logic [idx_w(NM)-1:0] i_last_grant,
  output logic [NM-1:0]        o_grant
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NM; k++) begin
      if (FIXED_PRIORITY != 0)
        w_idx = k;
      else
        w_idx = (int'(i_last_grant) + 1 + k) % NM;
      if (i_request[w_idx] && !w_found) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// bus_interconnect: NM masters arbitrated onto one path,
// decoded to NS slave windows with timeout and error response.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int NM = 3,
  parameter int NS = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NS*AW-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NS*AW-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
  parameter int TIMEOUT        = 255,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic            i_clock,
  input  logic            i_reset_n,
  input  logic [NM-1:0]   i_m_request,
  input  logic [NM-1:0]   i_m_rw,
  input  logic [NM*AW-1:0] i_m_address,
  input  logic [NM*DW-1:0] i_m_wdata,
  output logic [NM-1:0]   o_m_ready,
  output logic [DW-1:0]   o_m_rdata,
  output logic            o_m_fault,
  output logic [NS-1:0]   o_s_request,
  output logic            o_s_rw,
  output logic [AW-1:0]   o_s_address,
  output logic [DW-1:0]   o_s_wdata,
  input  logic [NS-1:0]   i_s_ready,
  input  logic [NS*DW-1:0] i_s_rdata,
  output logic            o_fault,
  output logic [AW-1:0]   o_fault_address
);

  localparam int MIW = idx_w(NM);
  localparam int SIW = idx_w(NS);
  localparam int CW  = idx_w(TIMEOUT + 1);
  localparam logic [NM-1:0] M_ONE  = NM'(1);
  localparam logic [NS-1:0] S_ONE  = NS'(1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  state_t         r_state, w_next;
  logic [MIW-1:0] r_midx, r_last, w_gidx;
  logic [SIW-1:0] r_sidx, w_hidx;
  logic [AW-1:0]  r_addr, w_gaddr;
  logic [CW-1:0]  r_cnt;
  logic [NM-1:0]  w_grant;
  logic [DW-1:0]  w_srdata;
  logic           w_hit, w_sready, w_tmo;

  bus_rr_arbiter #(
    .NM             (NM),
    .FIXED_PRIORITY (FIXED_PRIORITY)
  ) u_arb (
    .i_request    (i_m_request),
    .i_last_grant (r_last),
    .o_grant      (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NM; i++)
      if (w_grant[i]) w_gidx = MIW'(i);
  end

  assign w_gaddr = i_m_address[w_gidx*AW +: AW];

  // Descending scan so the lowest matching window wins.
  always_comb begin
    w_hit  = 1'b0;
    w_hidx = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((w_gaddr & SLAVE_MASK[i*AW +: AW]) ==
          SLAVE_BASE[i*AW +: AW]) begin
        w_hit  = 1'b1;
        w_hidx = SIW'(i);
      end
    end
  end

  assign w_sready = i_s_ready[r_sidx];
  assign w_srdata = i_s_rdata[r_sidx*DW +: DW];
  assign w_tmo    = (TIMEOUT != 0) && (r_cnt == C_LAST);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (|i_m_request)
          w_next = w_hit ? ACCESS : COMPLETE;
      ACCESS:
        if (w_sready || w_tmo) w_next = COMPLETE;
      COMPLETE: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_midx          <= '0;
      r_last          <= '0;
      r_sidx          <= '0;
      r_addr          <= '0;
      r_cnt           <= '0;
      o_m_ready       <= '0;
      o_m_rdata       <= '0;
      o_m_fault       <= 1'b0;
      o_s_request     <= '0;
      o_s_rw          <= 1'b0;
      o_s_address     <= '0;
      o_s_wdata       <= '0;
      o_fault         <= 1'b0;
      o_fault_address <= '0;
    end else begin
      o_m_ready <= '0;
      o_m_rdata <= '0;
      o_m_fault <= 1'b0;
      o_fault   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (|i_m_request) begin
            r_midx <= w_gidx;
            r_sidx <= w_hidx;
            r_addr <= w_gaddr;
            r_cnt  <= '0;
            if (w_hit) begin
              o_s_request <= S_ONE << w_hidx;
              o_s_rw      <= i_m_rw[w_gidx];
              o_s_address <= w_gaddr &
                             ~SLAVE_MASK[w_hidx*AW +: AW];
              o_s_wdata   <= i_m_wdata[w_gidx*DW +: DW];
            end else begin
              o_m_ready       <= M_ONE << w_gidx;
              o_m_fault       <= 1'b1;
              o_fault         <= 1'b1;
              o_fault_address <= w_gaddr;
            end
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_sready || w_tmo) begin
            o_s_request <= '0;
            o_m_ready   <= M_ONE << r_midx;
          end
          // Ready beats a coincident timeout.
          if (w_sready) begin
            o_m_rdata <= w_srdata;
          end else if (w_tmo) begin
            o_m_fault       <= 1'b1;
            o_fault         <= 1'b1;
            o_fault_address <= r_addr;
          end
        end
        COMPLETE: r_last <= r_midx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// tb_bus_interconnect: directed vector table plus hand-written
// sequences for arbitration, timeout, reset and priority.
module tb_bus_interconnect;

  logic        clk;
  logic        rst_n;
  logic [2:0]  m_req, m_rw;
  logic [95:0] m_addr, m_wdata;
  logic [1:0]  s_ready;
  logic [63:0] s_rdata;

  logic [2:0]  m_ready, m_ready2;
  logic [31:0] m_rdata, m_rdata2;
  logic        m_fault, m_fault2;
  logic [1:0]  s_req, s_req2;
  logic        s_rw, s_rw2;
  logic [31:0] s_addr, s_addr2, s_wdata, s_wdata2;
  logic        fault, fault2;
  logic [31:0] faddr, faddr2;

  int n_chk;
  int n_fail;

  bus_interconnect #(
    .TIMEOUT(8), .FIXED_PRIORITY(0)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_m_request(m_req), .i_m_rw(m_rw),
    .i_m_address(m_addr), .i_m_wdata(m_wdata),
    .o_m_ready(m_ready), .o_m_rdata(m_rdata),
    .o_m_fault(m_fault), .o_s_request(s_req),
    .o_s_rw(s_rw), .o_s_address(s_addr),
    .o_s_wdata(s_wdata), .i_s_ready(s_ready),
    .i_s_rdata(s_rdata), .o_fault(fault),
    .o_fault_address(faddr)
  );

  bus_interconnect #(
    .TIMEOUT(8), .FIXED_PRIORITY(1)
  ) dut_fp (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_m_request(m_req), .i_m_rw(m_rw),
    .i_m_address(m_addr), .i_m_wdata(m_wdata),
    .o_m_ready(m_ready2), .o_m_rdata(m_rdata2),
    .o_m_fault(m_fault2), .o_s_request(s_req2),
    .o_s_rw(s_rw2), .o_s_address(s_addr2),
    .o_s_wdata(s_wdata2), .i_s_ready(s_ready),
    .i_s_rdata(s_rdata), .o_fault(fault2),
    .o_fault_address(faddr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_m(input int m, input logic rw,
                       input logic [31:0] a,
                       input logic [31:0] d);
    m_rw[m]           = rw;
    m_addr[m*32 +: 32]  = a;
    m_wdata[m*32 +: 32] = d;
  endtask

  typedef struct {
    int          m;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0]  sreq;
    logic [31:0] saddr;
    logic [31:0] rdata;
    logic        flt;
    int          lat;
  } vec_t;

  vec_t vt[5];

  initial begin
    int          lat, cnt, n, prev;
    logic        got, seen, armed;
    logic [1:0]  c_sreq;
    logic        c_srw;
    logic [31:0] c_saddr, c_swdata, c_rdata, c_faddr;
    logic [2:0]  c_ready, any_rdy, seq_exp[6], alt_exp[6];
    logic        c_mf, c_f;

    n_chk  = 0;
    n_fail = 0;

    vt[0] = '{0, 1'b0, 32'h1000_0040, 32'h0,
              32'h1111_1111, 32'hDEAD_BEEF,
              2'b10, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 2};
    vt[1] = '{1, 1'b1, 32'h0ABC_DEF0, 32'hCAFE_F00D,
              32'h1234_5678, 32'h0,
              2'b01, 32'h0ABC_DEF0, 32'h1234_5678, 1'b0, 2};
    vt[2] = '{1, 1'b0, 32'h1FFF_FFFC, 32'h0,
              32'hAAAA_5555, 32'h5555_AAAA,
              2'b10, 32'h0FFF_FFFC, 32'h5555_AAAA, 1'b0, 2};
    vt[3] = '{0, 1'b0, 32'hF000_0000, 32'h0,
              32'h1, 32'h2,
              2'b00, 32'h0, 32'h0, 1'b1, 1};
    vt[4] = '{2, 1'b1, 32'h2000_0000, 32'h0BAD_F00D,
              32'h3, 32'h4,
              2'b00, 32'h0, 32'h0, 1'b1, 1};

    seq_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    alt_exp = '{3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001};

    rst_n   = 1'b0;
    m_req   = '0;
    m_rw    = '0;
    m_addr  = '0;
    m_wdata = '0;
    s_ready = '0;
    s_rdata = '0;
    cyc();
    cyc();
    chk("reset m_ready", 32'(m_ready), 32'h0);
    chk("reset s_request", 32'(s_req), 32'h0);
    chk("reset fault_addr", faddr, 32'h0);
    chk("reset m_rdata", m_rdata, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Single-master transactions from the vector table.
    for (int v = 0; v < 5; v++) begin
      set_m(vt[v].m, vt[v].rw, vt[v].addr, vt[v].wdata);
      m_req   = 3'b001 << vt[v].m;
      s_ready = 2'b11;
      s_rdata = {vt[v].rd1, vt[v].rd0};
      lat  = 0;
      got  = 1'b0;
      seen = 1'b0;
      c_sreq = '0; c_srw = 1'b0;
      c_saddr = '0; c_swdata = '0;
      c_ready = '0; c_rdata = '0;
      c_mf = 1'b0; c_f = 1'b0; c_faddr = '0;
      for (int c = 0; c < 10 && !got; c++) begin
        cyc();
        lat++;
        if (s_req != 2'b00 && !seen) begin
          seen     = 1'b1;
          c_sreq   = s_req;
          c_srw    = s_rw;
          c_saddr  = s_addr;
          c_swdata = s_wdata;
        end
        if (m_ready != 3'b000) begin
          got     = 1'b1;
          c_ready = m_ready;
          c_rdata = m_rdata;
          c_mf    = m_fault;
          c_f     = fault;
          c_faddr = faddr;
          m_req   = '0;
        end
      end
      chk($sformatf("v%0d ready seen", v), 32'(got), 32'h1);
      chk($sformatf("v%0d latency", v), lat, vt[v].lat);
      chk($sformatf("v%0d s_request", v), 32'(c_sreq),
          32'(vt[v].sreq));
      if (vt[v].sreq != 2'b00) begin
        chk($sformatf("v%0d s_address", v), c_saddr, vt[v].saddr);
        chk($sformatf("v%0d s_rw", v), 32'(c_srw), 32'(vt[v].rw));
        chk($sformatf("v%0d s_wdata", v), c_swdata, vt[v].wdata);
      end
      chk($sformatf("v%0d m_ready", v), 32'(c_ready),
          32'(3'b001 << vt[v].m));
      chk($sformatf("v%0d m_rdata", v), c_rdata, vt[v].rdata);
      chk($sformatf("v%0d m_fault", v), 32'(c_mf), 32'(vt[v].flt));
      chk($sformatf("v%0d o_fault", v), 32'(c_f), 32'(vt[v].flt));
      if (vt[v].flt)
        chk($sformatf("v%0d fault_addr", v), c_faddr, vt[v].addr);
      cyc();
      chk($sformatf("v%0d ready pulse", v), 32'(m_ready), 32'h0);
    end

    // Round-robin with all masters requesting continuously.
    for (int m = 0; m < 3; m++) set_m(m, 1'b0, 32'h0000_0100, 32'h0);
    m_req   = 3'b111;
    s_ready = 2'b11;
    s_rdata = {32'h0, 32'h0000_0ABC};
    n = 0; cnt = 0; prev = 0;
    for (int c = 0; c < 30 && n < 6; c++) begin
      cyc();
      cnt++;
      if (m_ready != 3'b000) begin
        chk($sformatf("rr grant %0d", n), 32'(m_ready),
            32'(seq_exp[n]));
        if (n > 0) chk($sformatf("rr spacing %0d", n), cnt - prev, 3);
        prev = cnt;
        n++;
        if (n == 6) m_req = '0;
      end
    end
    chk("rr ready count", n, 6);
    cyc();

    // Timeout with only the non-selected slave ready.
    set_m(0, 1'b0, 32'h0000_0010, 32'h0);
    m_req   = 3'b001;
    s_ready = 2'b10;
    s_rdata = {32'h9999_9999, 32'h7777_7777};
    cnt = 0; got = 1'b0;
    c_ready = '0; c_rdata = '1; c_mf = 1'b0; c_f = 1'b0; c_faddr = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      cyc();
      if (s_req[0]) cnt++;
      if (m_ready != 3'b000) begin
        got = 1'b1;
        c_ready = m_ready; c_rdata = m_rdata;
        c_mf = m_fault; c_f = fault; c_faddr = faddr;
        m_req = '0;
      end
    end
    chk("tmo access cycles", cnt, 8);
    chk("tmo m_ready", 32'(c_ready), 32'h1);
    chk("tmo m_fault", 32'(c_mf), 32'h1);
    chk("tmo o_fault", 32'(c_f), 32'h1);
    chk("tmo m_rdata", c_rdata, 32'h0);
    chk("tmo fault_addr", c_faddr, 32'h0000_0010);
    cyc();

    // Ready on the final allowed ACCESS cycle beats the timeout.
    set_m(1, 1'b0, 32'h0000_0020, 32'h0);
    m_req   = 3'b010;
    s_ready = 2'b00;
    cnt = 0; got = 1'b0; armed = 1'b0;
    c_ready = '0; c_rdata = '0; c_mf = 1'b1; c_f = 1'b1; c_faddr = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      cyc();
      if (s_req[0]) cnt++;
      if (cnt == 8 && !armed) begin
        armed   = 1'b1;
        s_ready = 2'b01;
      end
      if (m_ready != 3'b000) begin
        got = 1'b1;
        c_ready = m_ready; c_rdata = m_rdata;
        c_mf = m_fault; c_f = fault; c_faddr = faddr;
        m_req = '0;
      end
    end
    s_ready = 2'b00;
    chk("edge access cycles", cnt, 8);
    chk("edge m_ready", 32'(c_ready), 32'h2);
    chk("edge m_fault", 32'(c_mf), 32'h0);
    chk("edge o_fault", 32'(c_f), 32'h0);
    chk("edge m_rdata", c_rdata, 32'h7777_7777);
    chk("edge fault_addr held", c_faddr, 32'h0000_0010);
    cyc();

    // Reset in the middle of an ACCESS.
    set_m(0, 1'b0, 32'h0000_0030, 32'h0);
    m_req = 3'b001;
    cyc(); cyc(); cyc();
    chk("pre-reset s_request", 32'(s_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async s_request", 32'(s_req), 32'h0);
    chk("async s_address", s_addr, 32'h0);
    chk("async fault_addr", faddr, 32'h0);
    chk("async m_ready", 32'(m_ready), 32'h0);
    m_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    any_rdy = '0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      any_rdy = any_rdy | m_ready;
    end
    chk("no ready after reset", 32'(any_rdy), 32'h0);

    set_m(1, 1'b0, 32'h0000_0200, 32'h0);
    set_m(2, 1'b0, 32'h0000_0300, 32'h0);
    m_req   = 3'b110;
    s_ready = 2'b11;
    lat = 0; got = 1'b0; c_ready = '0;
    for (int c = 0; c < 6 && !got; c++) begin
      cyc();
      lat++;
      if (m_ready != 3'b000) begin
        got = 1'b1;
        c_ready = m_ready;
        m_req = '0;
      end
    end
    chk("post-reset first grant", 32'(c_ready), 32'h2);
    chk("post-reset latency", lat, 2);
    cyc(); cyc(); cyc();

    // Fixed priority versus round-robin on the same requests.
    set_m(0, 1'b0, 32'h0000_0400, 32'h0);
    set_m(2, 1'b0, 32'h0000_0500, 32'h0);
    m_req = 3'b101;
    n = 0; cnt = 0;
    for (int c = 0; c < 18; c++) begin
      cyc();
      if (m_ready2 != 3'b000) begin
        chk($sformatf("fp grant %0d", n), 32'(m_ready2), 32'h1);
        n++;
      end
      if (m_ready != 3'b000 && cnt < 6) begin
        chk($sformatf("rr alt grant %0d", cnt), 32'(m_ready),
            32'(alt_exp[cnt]));
        cnt++;
      end
    end
    m_req = '0;
    chk("fp ready count", n, 6);
    chk("rr alt count", cnt, 6);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_interconnect.md
Name: bus_interconnect

Overview:
- Parametrised successor to the fixed three-port bus arbiter plus hard-wired address decode used in the current SoC tops.
- Arbitrates NM masters onto one shared transaction path, then decodes the granted address against NS slave windows set by parameters.
- Strips the window base from the address before it reaches the slave.
- Adds what the current tops lack: round-robin or fixed-priority mode, a slave timeout, and an error response to the master on unmapped or timed-out accesses.

Parameters:
- NM, 3, number of masters; 1..8.
- NS, 2, number of slaves; 1..8.
- AW, 32, address width.
- DW, 32, data width.
- SLAVE_BASE, {32'h10000000, 32'h00000000}, packed NS*AW array of window bases; slave i occupies slice i.
- SLAVE_MASK, {32'hF0000000, 32'hF0000000}, packed NS*AW array of decode masks; slave i occupies slice i.
- TIMEOUT, 255, maximum number of ACCESS cycles before a fault is raised; 0 disables the timeout.
- FIXED_PRIORITY, 0, 0 selects round-robin arbitration; 1 makes the lowest master index always win.

Ports:
- i_clock  in  1  sole clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_m_request  in  NM  per-master request level.
- i_m_rw  in  NM  per-master direction; 1 = write.
- i_m_address  in  NM*AW  per-master address.
- i_m_wdata  in  NM*DW  per-master write data.
- o_m_ready  out  NM  one-cycle completion pulse to the owning master.
- o_m_rdata  out  DW  read data; valid while o_m_ready is high.
- o_m_fault  out  1  error flag; valid while o_m_ready is high.
- o_s_request  out  NS  one-hot slave request level.
- o_s_rw  out  1  shared direction to slaves.
- o_s_address  out  AW  shared address to slaves: latched_address & ~SLAVE_MASK[sel].
- o_s_wdata  out  DW  shared write data to slaves.
- i_s_ready  in  NS  per-slave ready.
- i_s_rdata  in  NS*DW  per-slave read data.
- o_fault  out  1  one-cycle pulse on any fault.
- o_fault_address  out  AW  full address of the most recent fault; held until the next fault.

Behaviour:
- Reset, asynchronous on i_reset_n low: every output goes to 0, state goes to IDLE, the round-robin pointer goes to 0 and the timeout counter clears. No ready pulse is issued for an interrupted transaction.
- State machine: IDLE -> ACCESS -> COMPLETE -> IDLE. An unmapped address goes IDLE -> COMPLETE directly.
- IDLE, arbitration:
  - If any i_m_request bit is set, pick a winner.
  - Round-robin: search starts at index last_grant+1 and wraps modulo NM.
  - Fixed priority: lowest set index wins.
  - Latch the winner index, address, rw and wdata. Master inputs are ignored after the latch.
- IDLE, decode:
  - Slave i matches when (addr & SLAVE_MASK[i]) == SLAVE_BASE[i].
  - If several windows match, the lowest index wins.
  - A match goes to ACCESS. No match goes to COMPLETE with fault=1.
- ACCESS:
  - Hold o_s_request[sel] high and o_s_rw/address/wdata stable. All other o_s_request bits stay 0.
  - The timeout counter increments every ACCESS cycle.
  - If i_s_ready[sel] is high, latch i_s_rdata[sel], set fault=0 and go to COMPLETE.
  - Otherwise, if TIMEOUT!=0 and counter == TIMEOUT-1, set rdata=0, fault=1 and go to COMPLETE.
  - If ready and timeout coincide, ready wins and no fault is raised.
  - Ready from a non-selected slave is ignored.
- COMPLETE:
  - o_s_request is all 0.
  - o_m_ready[winner] is 1 for exactly one cycle, with o_m_rdata and o_m_fault valid.
  - On fault, o_fault pulses and o_fault_address takes the latched address.
  - Update last_grant := winner, then return to IDLE.
- Latency: with a zero-wait slave (ready in the first ACCESS cycle), ready appears 2 cycles after the request is sampled. Minimum issue interval per transaction is 3 cycles.
- Master obligations:
  - Hold request and address until ready.
  - A request dropped early does not abort the transaction; the ready pulse is still issued.
  - A request still high after ready is treated as a new transaction.
- Outputs: o_m_rdata and o_m_fault are 0 outside COMPLETE. All outputs are registered.

Decomposition:
- Shared package bus_pkg:
  - state enum {IDLE, ACCESS, COMPLETE};
  - default-window constants;
  - clog2-based index-width localparams.
- Sub-module bus_rr_arbiter:
  - inputs: NM request vector, last_grant, FIXED_PRIORITY;
  - output: one-hot grant;
  - purely combinational; last_grant is held in the parent.

Test Plan:
- Master 0 reads 0x10000040; slave 1 ready in its first ACCESS cycle with rdata 0xDEADBEEF -> o_s_request=2'b10, o_s_address=0x00000040; o_m_ready[0] pulses 2 cycles after request sample with rdata 0xDEADBEEF and fault=0.
- All three masters hold requests continuously, zero-wait slave 0 -> grants in order 0,1,2,0,1,2, with ready pulses spaced 3 cycles apart.
- Master 2 writes 0x20000000 (unmapped) -> no o_s_request; o_m_ready[2] and o_m_fault both 1 one cycle after the sample; o_fault pulses; o_fault_address=0x20000000; o_m_rdata=0.
- TIMEOUT=8 and slave 0 never ready -> o_s_request[0] high for exactly 8 cycles, then ready with fault=1 and rdata=0; ready asserted on the 8th ACCESS cycle -> no fault.
- i_reset_n driven low mid-ACCESS -> all outputs 0 immediately with no ready pulse; after release, simultaneous requests from masters 1 and 2 grant master 1 first.
- FIXED_PRIORITY=1 with masters 0 and 2 holding requests -> master 0 is granted every time and master 2 is never granted.
